// File: rtl/cpu_pkg.sv
// Shared Y86-64 definitions: icodes, register specifiers, default width.
// Imported by the decode/write-back stage and its testbench.
package cpu_pkg;

    localparam int DATA_W_DEFAULT = 64;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef struct packed {
        logic [3:0] src_a;
        logic [3:0] src_b;
        logic [3:0] dst_e;
        logic [3:0] dst_m;
    } regsel_t;

endpackage

// File: rtl/decode_wb_scoreboard_if.sv
// Handshake/bus bundle for the decode stage: fetch in, execute out,
// and the two write-back return ports (E and M).
interface decode_wb_scoreboard_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        icode;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_icode;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;
    logic [3:0]        out_dstE;
    logic [3:0]        out_dstM;
    logic              wbE_valid;
    logic              wbE_wen;
    logic [3:0]        wbE_dst;
    logic [DATA_W-1:0] wbE_data;
    logic              wbM_valid;
    logic [3:0]        wbM_dst;
    logic [DATA_W-1:0] wbM_data;

    modport master (
        output in_valid, icode, rA, rB, out_ready,
        output wbE_valid, wbE_wen, wbE_dst, wbE_data,
        output wbM_valid, wbM_dst, wbM_data,
        input  in_ready, out_valid, out_icode,
        input  valA, valB, out_dstE, out_dstM
    );

    modport slave (
        input  in_valid, icode, rA, rB, out_ready,
        input  wbE_valid, wbE_wen, wbE_dst, wbE_data,
        input  wbM_valid, wbM_dst, wbM_data,
        output in_ready, out_valid, out_icode,
        output valA, valB, out_dstE, out_dstM
    );

endinterface

// File: rtl/regfile_2r2w.sv
// NREGS x DATA_W register file: 2 combinational reads, 2 synchronous
// writes (port M wins on collision). Ports: clock, reset, ra/rd a/b, e/m write.
module regfile_2r2w #(
    parameter int NREGS  = 15,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        ra_a,
    input  logic [3:0]        ra_b,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    input  logic              we_e,
    input  logic [3:0]        wa_e,
    input  logic [DATA_W-1:0] wd_e,
    input  logic              we_m,
    input  logic [3:0]        wa_m,
    input  logic [DATA_W-1:0] wd_m
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // Addresses outside the array (RNONE) read 0 and are never written.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (ra_a == 4'(i)) rd_a = regs_q[i];
            if (ra_b == 4'(i)) rd_b = regs_q[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (we_e && wa_e == 4'(i)) regs_d[i] = wd_e;
            if (we_m && wa_m == 4'(i)) regs_d[i] = wd_m;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
        end
    end

endmodule

// File: rtl/decode_wb_scoreboard.sv
// Y86-64 decode/write-back stage with a pend scoreboard and output register.
// Ports: clock, reset, bus (slave). Option macro: DECODE_BYPASS_EN.
module decode_wb_scoreboard
    import cpu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int NREGS   = 15,
    parameter int RSP_IDX = 4
) (
    input logic                  clock,
    input logic                  reset,
    decode_wb_scoreboard_if.slave bus
);

    localparam logic [3:0] RSP = 4'(RSP_IDX);

    function automatic logic [NREGS-1:0] onehot(input logic [3:0] r);
        logic [NREGS-1:0] v;
        v = '0;
        for (int i = 0; i < NREGS; i++) v[i] = (r == 4'(i));
        return v;
    endfunction

    regsel_t           sel;
    logic [NREGS-1:0]  pend_e_q, pend_e_d;
    logic [NREGS-1:0]  pend_m_q, pend_m_d;
    logic [NREGS-1:0]  ret_e, ret_m, busy, used;
    logic              hazard, accept;
    logic [DATA_W-1:0] rd_a, rd_b, op_a, op_b;

    logic              out_valid_q, out_valid_d;
    logic [3:0]        out_icode_q, out_icode_d;
    logic [DATA_W-1:0] val_a_q, val_a_d;
    logic [DATA_W-1:0] val_b_q, val_b_d;
    logic [3:0]        dst_e_q, dst_e_d;
    logic [3:0]        dst_m_q, dst_m_d;

    always_comb begin
        sel = '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
        case (bus.icode)
            IRRMOVQ: begin
                sel.src_a = bus.rA;
                sel.dst_e = bus.rB;
            end
            IIRMOVQ: sel.dst_e = bus.rB;
            IRMMOVQ: begin
                sel.src_a = bus.rA;
                sel.src_b = bus.rB;
            end
            IMRMOVQ: begin
                sel.src_b = bus.rB;
                sel.dst_m = bus.rA;
            end
            IOPQ: begin
                sel.src_a = bus.rA;
                sel.src_b = bus.rB;
                sel.dst_e = bus.rB;
            end
            ICALL: begin
                sel.src_b = RSP;
                sel.dst_e = RSP;
            end
            IRET: begin
                sel.src_a = RSP;
                sel.src_b = RSP;
                sel.dst_e = RSP;
            end
            IPUSHQ: begin
                sel.src_a = bus.rA;
                sel.src_b = RSP;
                sel.dst_e = RSP;
            end
            IPOPQ: begin
                sel.src_a = RSP;
                sel.src_b = RSP;
                sel.dst_e = RSP;
                sel.dst_m = bus.rA;
            end
            default: ;
        endcase
    end

    // A retire clears its own pend bit regardless of wen (cmov not taken).
    assign ret_e = bus.wbE_valid ? onehot(bus.wbE_dst) : '0;
    assign ret_m = bus.wbM_valid ? onehot(bus.wbM_dst) : '0;

`ifdef DECODE_BYPASS_EN
    // Retiring this cycle counts as free unless the other port still owns it.
    assign busy = (pend_e_q & ~ret_e) | (pend_m_q & ~ret_m);
`else
    assign busy = pend_e_q | pend_m_q;
`endif

    assign used = onehot(sel.src_a) | onehot(sel.src_b)
                | onehot(sel.dst_e) | onehot(sel.dst_m);
    assign hazard = |(busy & used);
    assign bus.in_ready = !hazard && (!out_valid_q || bus.out_ready);
    assign accept = bus.in_valid && bus.in_ready;

    // Clears first, then the accepted instruction's sets.
    assign pend_e_d = (pend_e_q & ~ret_e) | (accept ? onehot(sel.dst_e) : '0);
    assign pend_m_d = (pend_m_q & ~ret_m) | (accept ? onehot(sel.dst_m) : '0);

    regfile_2r2w #(
        .NREGS  (NREGS),
        .DATA_W (DATA_W)
    ) u_rf (
        .clock (clock),
        .reset (reset),
        .ra_a  (sel.src_a),
        .ra_b  (sel.src_b),
        .rd_a  (rd_a),
        .rd_b  (rd_b),
        .we_e  (bus.wbE_valid && bus.wbE_wen),
        .wa_e  (bus.wbE_dst),
        .wd_e  (bus.wbE_data),
        .we_m  (bus.wbM_valid),
        .wa_m  (bus.wbM_dst),
        .wd_m  (bus.wbM_data)
    );

`ifdef DECODE_BYPASS_EN
    // M forwarding is applied last so it wins over E, like the array write.
    always_comb begin
        op_a = rd_a;
        op_b = rd_b;
        if (bus.wbE_wen && |(ret_e & onehot(sel.src_a))) op_a = bus.wbE_data;
        if (bus.wbE_wen && |(ret_e & onehot(sel.src_b))) op_b = bus.wbE_data;
        if (|(ret_m & onehot(sel.src_a))) op_a = bus.wbM_data;
        if (|(ret_m & onehot(sel.src_b))) op_b = bus.wbM_data;
    end
`else
    assign op_a = rd_a;
    assign op_b = rd_b;
`endif

    always_comb begin
        out_icode_d = out_icode_q;
        val_a_d     = val_a_q;
        val_b_d     = val_b_q;
        dst_e_d     = dst_e_q;
        dst_m_d     = dst_m_q;
        out_valid_d = bus.out_ready ? 1'b0 : out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_icode_d = bus.icode;
            val_a_d     = op_a;
            val_b_d     = op_b;
            dst_e_d     = sel.dst_e;
            dst_m_d     = sel.dst_m;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_e_q    <= '0;
            pend_m_q    <= '0;
            out_valid_q <= 1'b0;
            out_icode_q <= IHALT;
            val_a_q     <= '0;
            val_b_q     <= '0;
            dst_e_q     <= RNONE;
            dst_m_q     <= RNONE;
        end else begin
            pend_e_q    <= pend_e_d;
            pend_m_q    <= pend_m_d;
            out_valid_q <= out_valid_d;
            out_icode_q <= out_icode_d;
            val_a_q     <= val_a_d;
            val_b_q     <= val_b_d;
            dst_e_q     <= dst_e_d;
            dst_m_q     <= dst_m_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_icode = out_icode_q;
    assign bus.valA      = val_a_q;
    assign bus.valB      = val_b_q;
    assign bus.out_dstE  = dst_e_q;
    assign bus.out_dstM  = dst_m_q;

endmodule

// File: tb/tb_decode_wb_scoreboard.sv
// Directed + random bench for decode_wb_scoreboard against a behavioural model.
// Honours DECODE_BYPASS_EN the same way the design does.
module tb_decode_wb_scoreboard;
    import cpu_pkg::*;

    localparam int DW = 64;
`ifdef DECODE_BYPASS_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    decode_wb_scoreboard_if #(.DATA_W(DW)) bus ();

    decode_wb_scoreboard #(
        .DATA_W  (DW),
        .NREGS   (15),
        .RSP_IDX (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mregs [16];
    bit            mpe [16];
    bit            mpm [16];
    bit            m_ov;
    logic [3:0]    m_ic, m_de, m_dm;
    logic [DW-1:0] m_va, m_vb;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 16; i++) begin
            mregs[i] = '0;
            mpe[i] = 1'b0;
            mpm[i] = 1'b0;
        end
        m_ov = 1'b0;
        m_ic = IHALT;
        m_de = RNONE;
        m_dm = RNONE;
        m_va = '0;
        m_vb = '0;
    endtask

    // Register roles per instruction, straight from the ISA table.
    task automatic roles(input logic [3:0] ic, a, b,
                         output logic [3:0] sa, sb, de, dm);
        sa = RNONE; sb = RNONE; de = RNONE; dm = RNONE;
        if (ic inside {IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ}) sa = a;
        if (ic inside {IPOPQ, IRET}) sa = RRSP;
        if (ic inside {IOPQ, IRMMOVQ, IMRMOVQ}) sb = b;
        if (ic inside {IPUSHQ, IPOPQ, ICALL, IRET}) sb = RRSP;
        if (ic inside {IRRMOVQ, IIRMOVQ, IOPQ}) de = b;
        if (ic inside {IPUSHQ, IPOPQ, ICALL, IRET}) de = RRSP;
        if (ic inside {IMRMOVQ, IPOPQ}) dm = a;
    endtask

    function automatic bit mbusy(input logic [3:0] r);
        bit e, m;
        if (r == RNONE) return 1'b0;
        e = mpe[r] && !(BP && bus.wbE_valid && bus.wbE_dst == r);
        m = mpm[r] && !(BP && bus.wbM_valid && bus.wbM_dst == r);
        return e || m;
    endfunction

    function automatic logic [DW-1:0] mop(input logic [3:0] r);
        if (r == RNONE) return '0;
        if (BP && bus.wbM_valid && bus.wbM_dst == r) return bus.wbM_data;
        if (BP && bus.wbE_valid && bus.wbE_wen && bus.wbE_dst == r)
            return bus.wbE_data;
        return mregs[r];
    endfunction

    // One clock: check in_ready before the edge, advance model, check outputs.
    task automatic step(output bit dacc);
        logic [3:0]    sa, sb, de, dm;
        logic [DW-1:0] na, nb;
        bit            rdy, acc;
        #1;
        roles(bus.icode, bus.rA, bus.rB, sa, sb, de, dm);
        rdy = !(mbusy(sa) || mbusy(sb) || mbusy(de) || mbusy(dm))
              && (!m_ov || bus.out_ready);
        if (!reset) chk("in_ready", 64'(bus.in_ready), 64'(rdy));
        dacc = bus.in_valid && bus.in_ready;
        acc = bus.in_valid && rdy && !reset;
        na = mop(sa);
        nb = mop(sb);
        @(posedge clock);
        #1;
        if (reset) begin
            mreset();
        end else begin
            if (bus.wbE_valid && bus.wbE_wen && bus.wbE_dst != RNONE)
                mregs[bus.wbE_dst] = bus.wbE_data;
            if (bus.wbM_valid && bus.wbM_dst != RNONE)
                mregs[bus.wbM_dst] = bus.wbM_data;
            if (bus.wbE_valid && bus.wbE_dst != RNONE) mpe[bus.wbE_dst] = 1'b0;
            if (bus.wbM_valid && bus.wbM_dst != RNONE) mpm[bus.wbM_dst] = 1'b0;
            if (acc) begin
                if (de != RNONE) mpe[de] = 1'b1;
                if (dm != RNONE) mpm[dm] = 1'b1;
                m_ov = 1'b1;
                m_ic = bus.icode;
                m_va = na;
                m_vb = nb;
                m_de = de;
                m_dm = dm;
            end else if (bus.out_ready) begin
                m_ov = 1'b0;
            end
        end
        chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
        chk("out_icode", 64'(bus.out_icode), 64'(m_ic));
        chk("valA", bus.valA, m_va);
        chk("valB", bus.valB, m_vb);
        chk("out_dstE", 64'(bus.out_dstE), 64'(m_de));
        chk("out_dstM", 64'(bus.out_dstM), 64'(m_dm));
    endtask

    task automatic wb_idle();
        bus.wbE_valid = 1'b0;
        bus.wbE_wen   = 1'b0;
        bus.wbM_valid = 1'b0;
    endtask

    task automatic wbe(input logic [3:0] r, input logic [DW-1:0] d,
                       input bit wen);
        bus.wbE_valid = 1'b1;
        bus.wbE_wen   = wen;
        bus.wbE_dst   = r;
        bus.wbE_data  = d;
    endtask

    task automatic present(input logic [3:0] ic, a, b);
        bus.in_valid = 1'b1;
        bus.icode    = ic;
        bus.rA       = a;
        bus.rB       = b;
    endtask

    task automatic issue(input logic [3:0] ic, a, b);
        bit d;
        int n;
        present(ic, a, b);
        n = 0;
        d = 1'b0;
        while (!d && n < 8) begin
            step(d);
            n++;
        end
        if (!d) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout icode=%0h accepted=0 required=1", ic);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bit d;
        int lat;
        bus.in_valid  = 1'b0;
        bus.icode     = INOP;
        bus.rA        = RNONE;
        bus.rB        = RNONE;
        bus.out_ready = 1'b1;
        bus.wbE_dst   = RNONE;
        bus.wbE_data  = '0;
        bus.wbM_dst   = RNONE;
        bus.wbM_data  = '0;
        wb_idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        mreset();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_dstE", 64'(bus.out_dstE), 64'(RNONE));
        chk("rst_dstM", 64'(bus.out_dstM), 64'(RNONE));
        chk("rst_icode", 64'(bus.out_icode), 64'(IHALT));
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        reset = 1'b0;

        // irmovq -> rB=2, then dependent opq waits for its write-back.
        issue(IIRMOVQ, RNONE, 4'h2);
        chk("irmovq_dstE", 64'(bus.out_dstE), 64'h2);
        present(IOPQ, 4'h2, 4'h5);
        step(d);
        chk("raw_stall", 64'(d), 64'd0);
        wbe(4'h2, 64'h55, 1'b1);
        step(d);
        wb_idle();
        lat = 0;
        while (!d && lat < 6) begin
            step(d);
            lat++;
        end
        bus.in_valid = 1'b0;
        chk("issue_lat", 64'(lat), BP ? 64'd0 : 64'd1);
        chk("valA_55", bus.valA, 64'h55);
        wbe(4'h5, 64'h77, 1'b1);
        step(d);
        wb_idle();

        // popq %rsp: both ports retire rsp together, M wins.
        issue(IPOPQ, 4'h4, RNONE);
        wbe(4'h4, 64'h100, 1'b1);
        bus.wbM_valid = 1'b1;
        bus.wbM_dst   = 4'h4;
        bus.wbM_data  = 64'h200;
        step(d);
        wb_idle();
        step(d);
        issue(IRRMOVQ, 4'h4, 4'h6);
        chk("popq_rsp", bus.valA, 64'h200);
        wbe(4'h6, 64'h200, 1'b1);
        step(d);
        wb_idle();

        // cmov not taken: clear only, no write.
        issue(IRRMOVQ, 4'h1, 4'h3);
        wbe(4'h3, 64'hdead, 1'b0);
        step(d);
        wb_idle();
        step(d);
        issue(IOPQ, 4'h3, 4'h1);
        chk("cmov_nt_val", bus.valA, 64'h0);
        wbe(4'h1, 64'h11, 1'b1);
        step(d);
        wb_idle();

        // Back-pressure: 3 cycles held, second instruction waits.
        issue(IOPQ, 4'h1, 4'h8);
        bus.out_ready = 1'b0;
        present(IIRMOVQ, RNONE, 4'h9);
        for (int i = 0; i < 3; i++) begin
            step(d);
            chk("stall_hold", 64'(d), 64'd0);
        end
        bus.out_ready = 1'b1;
        step(d);
        chk("stall_release", 64'(d), 64'd1);
        bus.in_valid = 1'b0;
        step(d);

        // Reset while stalled with pend bits set.
        bus.out_ready = 1'b0;
        present(IRRMOVQ, 4'h2, 4'h7);
        step(d);
        step(d);
        reset = 1'b1;
        step(d);
        reset = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("rst2_out_valid", 64'(bus.out_valid), 64'd0);
        step(d);
        issue(IRRMOVQ, 4'h2, 4'h7);
        chk("rst2_regs_zero", bus.valA, 64'h0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.icode     = 4'($urandom_range(0, 13));
            bus.rA        = 4'($urandom_range(0, 15));
            bus.rB        = 4'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.wbE_valid = ($urandom_range(0, 1) != 0);
            bus.wbE_wen   = ($urandom_range(0, 3) != 0);
            bus.wbE_dst   = 4'($urandom_range(0, 15));
            bus.wbE_data  = {$urandom, $urandom};
            bus.wbM_valid = ($urandom_range(0, 2) == 0);
            bus.wbM_dst   = ($urandom_range(0, 3) == 0) ? bus.wbE_dst
                                                        : 4'($urandom_range(0, 15));
            bus.wbM_data  = {$urandom, $urandom};
            step(d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
